// File: rtl/axi_lite_regfile_if.sv
// AXI4-Lite slave-side bundle: five channels with valid/ready handshakes.
// The master modport drives requests; the slave modport drives readies and responses.
interface axi_lite_regfile_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   awaddr;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  logic [ADDR_W-1:0]   araddr;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axi_lite_regfile.sv
// Parametrised AXI4-Lite register file with RO status slots, byte strobes and SLVERR.
// Write: commit one edge after both AW and W are held; read: data one edge after AR; B/R held until ready.
module axi_lite_regfile #(
  parameter int                  DATA_W   = 32,
  parameter int                  ADDR_W   = 6,
  parameter int                  NUM_REGS = 8,
  parameter logic [NUM_REGS-1:0] RO_MASK  = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  axi_lite_regfile_if.slave          s_axi,
  output logic [NUM_REGS*DATA_W-1:0] reg_q,
  input  logic [NUM_REGS*DATA_W-1:0] hw_status,
  output logic [NUM_REGS-1:0]        wr_pulse
);
  localparam int STRB_W = DATA_W / 8;
  localparam int LSB    = $clog2(STRB_W);
  localparam int IDX_W  = ADDR_W - LSB;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  function automatic logic [DATA_W-1:0] merge_bytes(input logic [DATA_W-1:0] old_v,
                                                    input logic [DATA_W-1:0] new_v,
                                                    input logic [STRB_W-1:0] strb);
    logic [DATA_W-1:0] r;
    r = old_v;
    for (int b = 0; b < STRB_W; b++) begin
      if (strb[b]) r[b*8 +: 8] = new_v[b*8 +: 8];
    end
    return r;
  endfunction

  // ---------------- write path ----------------
  logic                aw_full_q;
  logic [IDX_W-1:0]    aw_idx_q;
  logic                w_full_q;
  logic [DATA_W-1:0]   w_data_q;
  logic [STRB_W-1:0]   w_strb_q;
  logic                b_vld_q;
  logic [1:0]          b_resp_q;
  logic [NUM_REGS-1:0] wr_pulse_q;
  logic [DATA_W-1:0]   regs_q [NUM_REGS];

  logic                commit;
  logic                aw_hs;
  logic                w_hs;
  logic                wr_legal;
  logic [NUM_REGS-1:0] wr_sel;

  assign commit        = aw_full_q && w_full_q;
  assign s_axi.awready = !rst && !aw_full_q && !b_vld_q && !commit;
  assign s_axi.wready  = !rst && !w_full_q && !b_vld_q && !commit;
  assign aw_hs         = s_axi.awvalid && s_axi.awready;
  assign w_hs          = s_axi.wvalid && s_axi.wready;
  assign s_axi.bvalid  = b_vld_q;
  assign s_axi.bresp   = b_resp_q;
  assign wr_pulse      = wr_pulse_q;

  // Out-of-range and read-only targets both leave wr_sel empty, which is what makes them SLVERR.
  always_comb begin
    wr_legal = 1'b0;
    wr_sel   = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (aw_idx_q == IDX_W'(i) && !RO_MASK[i]) begin
        wr_legal  = 1'b1;
        wr_sel[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      aw_full_q  <= 1'b0;
      aw_idx_q   <= '0;
      w_full_q   <= 1'b0;
      w_data_q   <= '0;
      w_strb_q   <= '0;
      b_vld_q    <= 1'b0;
      b_resp_q   <= RESP_OKAY;
      wr_pulse_q <= '0;
    end else begin
      wr_pulse_q <= '0;
      if (aw_hs) begin
        aw_full_q <= 1'b1;
        aw_idx_q  <= s_axi.awaddr[ADDR_W-1:LSB];
      end
      if (w_hs) begin
        w_full_q <= 1'b1;
        w_data_q <= s_axi.wdata;
        w_strb_q <= s_axi.wstrb;
      end
      if (commit) begin
        aw_full_q  <= 1'b0;
        w_full_q   <= 1'b0;
        b_vld_q    <= 1'b1;
        b_resp_q   <= wr_legal ? RESP_OKAY : RESP_SLVERR;
        wr_pulse_q <= wr_sel;
      end else if (b_vld_q && s_axi.bready) begin
        b_vld_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else if (commit) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wr_sel[i]) regs_q[i] <= merge_bytes(regs_q[i], w_data_q, w_strb_q);
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_out
    assign reg_q[g*DATA_W +: DATA_W] = RO_MASK[g] ? '0 : regs_q[g];
  end

  // ---------------- read path ----------------
  // One pending slot sits in front of the R register; it lets a new AR land while the
  // previous response is being formed, giving one read per two cycles when rready is high.
  logic              ar_pend_q;
  logic [IDX_W-1:0]  ar_idx_q;
  logic              r_vld_q;
  logic [DATA_W-1:0] r_data_q;
  logic [1:0]        r_resp_q;

  logic              ar_hs;
  logic              promote;
  logic              rd_hit;
  logic [DATA_W-1:0] rd_data;

  assign s_axi.arready = !rst && !r_vld_q;
  assign ar_hs         = s_axi.arvalid && s_axi.arready;
  assign promote       = ar_pend_q && !r_vld_q;
  assign s_axi.rvalid  = r_vld_q;
  assign s_axi.rdata   = r_data_q;
  assign s_axi.rresp   = r_resp_q;

  always_comb begin
    rd_hit  = 1'b0;
    rd_data = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (ar_idx_q == IDX_W'(i)) begin
        rd_hit  = 1'b1;
        rd_data = RO_MASK[i] ? hw_status[i*DATA_W +: DATA_W] : regs_q[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ar_pend_q <= 1'b0;
      ar_idx_q  <= '0;
      r_vld_q   <= 1'b0;
      r_data_q  <= '0;
      r_resp_q  <= RESP_OKAY;
    end else begin
      if (r_vld_q && s_axi.rready) begin
        r_vld_q <= 1'b0;
      end else if (promote) begin
        r_vld_q  <= 1'b1;
        r_data_q <= rd_data;
        r_resp_q <= rd_hit ? RESP_OKAY : RESP_SLVERR;
      end
      if (ar_hs) begin
        ar_pend_q <= 1'b1;
        ar_idx_q  <= s_axi.araddr[ADDR_W-1:LSB];
      end else if (promote) begin
        ar_pend_q <= 1'b0;
      end
    end
  end

  // Sub-word address bits and status slices of writable registers are intentionally ignored.
  logic unused_bits;
  assign unused_bits = ^{s_axi.awaddr[LSB-1:0], s_axi.araddr[LSB-1:0], hw_status};
endmodule

// File: tb/tb_axi_lite_regfile.sv
// Self-checking bench for axi_lite_regfile: vector table, hand-written corner sequences,
// and randomized traffic scored against an array-based reference model.
module tb_axi_lite_regfile;
  localparam int AW = 6;
  localparam int DW = 32;
  localparam int NR = 8;
  localparam logic [NR-1:0] RO = 8'h80;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axi_lite_regfile_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
  logic [NR*DW-1:0] reg_q;
  logic [NR*DW-1:0] hw_status;
  logic [NR-1:0]    wr_pulse;

  axi_lite_regfile #(.DATA_W(DW), .ADDR_W(AW), .NUM_REGS(NR), .RO_MASK(RO)) dut (
    .clk(clk), .rst(rst), .s_axi(bus), .reg_q(reg_q), .hw_status(hw_status), .wr_pulse(wr_pulse)
  );

  axi_lite_regfile_if #(.ADDR_W(AW), .DATA_W(64)) bus64 ();
  logic [4*64-1:0] reg_q64;
  logic [4*64-1:0] hw_status64;
  logic [3:0]      wr_pulse64;

  axi_lite_regfile #(.DATA_W(64), .ADDR_W(AW), .NUM_REGS(4), .RO_MASK(4'h0)) dut64 (
    .clk(clk), .rst(rst), .s_axi(bus64), .reg_q(reg_q64), .hw_status(hw_status64), .wr_pulse(wr_pulse64)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    bit          wr;
    logic [5:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  exp_resp;
    logic [31:0] exp_rdata;
    logic [7:0]  exp_pulse;
  } vec_t;

  vec_t vt [11];
  logic [31:0] mdl [NR];

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: timed out waiting on DUT", name);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    #1;
    for (int i = 0; i < NR; i++) mdl[i] = '0;
  endtask

  task automatic axi_wr(input logic [AW-1:0] addr, input logic [31:0] data, input logic [3:0] strb,
                        output logic [1:0] resp, output logic [NR-1:0] pulse, output int lat);
    bit aw_hs, w_hs, aw_done, w_done;
    int c;
    aw_done = 0; w_done = 0; c = 0; lat = 0;
    resp = 2'bxx; pulse = 'x;
    bus.awaddr = addr; bus.wdata = data; bus.wstrb = strb;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1;
    while (!(aw_done && w_done) && c < 20) begin
      aw_hs = bus.awvalid && bus.awready;
      w_hs  = bus.wvalid && bus.wready;
      tick();
      c++;
      if (aw_hs) begin aw_done = 1; bus.awvalid = 1'b0; end
      if (w_hs)  begin w_done = 1;  bus.wvalid = 1'b0;  end
    end
    if (!(aw_done && w_done)) begin
      bus.awvalid = 1'b0; bus.wvalid = 1'b0;
      fail_now("wr_handshake");
      return;
    end
    while (!bus.bvalid && lat < 20) begin tick(); lat++; end
    if (!bus.bvalid) fail_now("wr_bvalid");
    resp  = bus.bresp;
    pulse = wr_pulse;
  endtask

  task automatic axi_rd(input logic [AW-1:0] addr, output logic [31:0] data,
                        output logic [1:0] resp, output int lat);
    bit hs;
    int c;
    hs = 0; c = 0; lat = 0;
    data = 'x; resp = 2'bxx;
    bus.araddr = addr; bus.arvalid = 1'b1;
    while (!hs && c < 20) begin
      hs = bus.arready;
      tick();
      c++;
    end
    bus.arvalid = 1'b0;
    if (!hs) begin fail_now("rd_handshake"); return; end
    while (!bus.rvalid && lat < 20) begin tick(); lat++; end
    if (!bus.rvalid) fail_now("rd_rvalid");
    data = bus.rdata;
    resp = bus.rresp;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]       resp;
    logic [NR-1:0]    pulse;
    logic [31:0]      rdata;
    logic [NR*DW-1:0] exp_vec;
    int               lat;
    int               c;

    bus.awaddr = '0; bus.awvalid = 0; bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 0;
    bus.bready = 1; bus.araddr = '0; bus.arvalid = 0; bus.rready = 1;
    bus64.awaddr = '0; bus64.awvalid = 0; bus64.wdata = '0; bus64.wstrb = '0; bus64.wvalid = 0;
    bus64.bready = 1; bus64.araddr = '0; bus64.arvalid = 0; bus64.rready = 1;
    hw_status64 = '0;
    for (int i = 0; i < NR; i++) hw_status[i*DW +: DW] = 32'hA5A5A5A5;
    hw_status[7*DW +: DW] = 32'h12345678;

    // Reset held for three cycles: every output low.
    for (int i = 0; i < 3; i++) begin
      tick();
      check("reset_ctrl", {bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid,
                           bus.bresp, bus.rresp, wr_pulse}, '0);
      check("reset_data", {bus.rdata, reg_q}, '0);
    end
    rst = 1'b0;
    #1;
    check("ready_after_reset", {bus.awready, bus.wready, bus.arready}, 3'b111);
    check("regq_after_reset", reg_q, '0);

    vt[0]  = '{1'b1, 6'h04, 32'hDEADBEEF, 4'hF, 2'b00, 32'h0,        8'h02};
    vt[1]  = '{1'b0, 6'h04, 32'h0,        4'h0, 2'b00, 32'hDEADBEEF, 8'h00};
    vt[2]  = '{1'b1, 6'h08, 32'h11223344, 4'hF, 2'b00, 32'h0,        8'h04};
    vt[3]  = '{1'b1, 6'h3C, 32'hCAFEF00D, 4'hF, 2'b10, 32'h0,        8'h00};
    vt[4]  = '{1'b0, 6'h3C, 32'h0,        4'h0, 2'b10, 32'h0,        8'h00};
    vt[5]  = '{1'b1, 6'h1C, 32'hFFFFFFFF, 4'hF, 2'b10, 32'h0,        8'h00};
    vt[6]  = '{1'b0, 6'h1C, 32'h0,        4'h0, 2'b00, 32'h12345678, 8'h00};
    vt[7]  = '{1'b1, 6'h07, 32'h00000000, 4'h8, 2'b00, 32'h0,        8'h02};
    vt[8]  = '{1'b0, 6'h05, 32'h0,        4'h0, 2'b00, 32'h00ADBEEF, 8'h00};
    vt[9]  = '{1'b0, 6'h20, 32'h0,        4'h0, 2'b10, 32'h0,        8'h00};
    vt[10] = '{1'b0, 6'h08, 32'h0,        4'h0, 2'b00, 32'h11223344, 8'h00};

    for (int v = 0; v < 11; v++) begin
      if (vt[v].wr) begin
        axi_wr(vt[v].addr, vt[v].data, vt[v].strb, resp, pulse, lat);
        check($sformatf("vec%0d_bresp", v), resp, vt[v].exp_resp);
        check($sformatf("vec%0d_pulse", v), pulse, vt[v].exp_pulse);
        check($sformatf("vec%0d_wlat", v), lat, 1);
        tick();
        check($sformatf("vec%0d_pulse_gone", v), wr_pulse, '0);
      end else begin
        axi_rd(vt[v].addr, rdata, resp, lat);
        check($sformatf("vec%0d_rdata", v), rdata, vt[v].exp_rdata);
        check($sformatf("vec%0d_rresp", v), resp, vt[v].exp_resp);
        check($sformatf("vec%0d_rlat", v), lat, 1);
      end
    end
    exp_vec = '0;
    exp_vec[1*DW +: DW] = 32'h00ADBEEF;
    exp_vec[2*DW +: DW] = 32'h11223344;
    tick();
    check("regq_after_table", reg_q, exp_vec);

    // W arrives three cycles ahead of AW; response counts from the AW handshake.
    bus.wdata = 32'hAABBCCDD; bus.wstrb = 4'b0101; bus.wvalid = 1'b1;
    check("split_wready", bus.wready, 1'b1);
    tick();
    bus.wvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("split_no_b_early", bus.bvalid, 1'b0);
    end
    bus.awaddr = 6'h08; bus.awvalid = 1'b1;
    check("split_awready", bus.awready, 1'b1);
    tick();
    bus.awvalid = 1'b0;
    check("split_b_not_yet", bus.bvalid, 1'b0);
    tick();
    check("split_bvalid", {bus.bvalid, bus.bresp, wr_pulse}, {1'b1, 2'b00, 8'h04});
    check("split_reg2", reg_q[2*DW +: DW], 32'h11BB33DD);
    tick();

    // B backpressure.
    bus.bready = 1'b0;
    axi_wr(6'h0C, 32'h55AA55AA, 4'hF, resp, pulse, lat);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_b_hold", {bus.bvalid, bus.bresp, bus.awready, bus.wready}, {1'b1, 2'b00, 1'b0, 1'b0});
    end
    bus.bready = 1'b1;
    tick();
    check("bp_b_release", {bus.bvalid, bus.awready}, 2'b01);

    // R backpressure.
    bus.rready = 1'b0;
    axi_rd(6'h0C, rdata, resp, lat);
    check("bp_r_first", rdata, 32'h55AA55AA);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_r_hold", {bus.rvalid, bus.rdata, bus.rresp, bus.arready}, {1'b1, 32'h55AA55AA, 2'b00, 1'b0});
    end
    bus.rready = 1'b1;
    tick();
    check("bp_r_release", {bus.rvalid, bus.arready}, 2'b01);

    // Read data registered on the commit edge sees the pre-write value.
    bus.awaddr = 6'h04; bus.wdata = 32'h13572468; bus.wstrb = 4'hF; bus.araddr = 6'h04;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.arvalid = 1'b1;
    check("coll_ready", {bus.awready, bus.wready, bus.arready}, 3'b111);
    tick();
    bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
    tick();
    check("coll_valids", {bus.rvalid, bus.bvalid}, 2'b11);
    check("coll_rdata_old", bus.rdata, 32'h00ADBEEF);
    check("coll_reg1_new", reg_q[1*DW +: DW], 32'h13572468);
    tick();

    // Reset with AW captured but W not yet sent: the AW is lost.
    bus.awaddr = 6'h04; bus.awvalid = 1'b1;
    check("midrst_awready", bus.awready, 1'b1);
    tick();
    bus.awvalid = 1'b0;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    #1;
    check("midrst_regq", reg_q, '0);
    bus.wdata = 32'hFFFFFFFF; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
    tick();
    bus.wvalid = 1'b0;
    c = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus.bvalid) c++;
    end
    check("midrst_no_bvalid", c, 0);
    check("midrst_regq_after_w", reg_q, '0);

    // 64-bit instance: write then read back register 1.
    bus64.awaddr = 6'h08; bus64.wdata = 64'h0123456789ABCDEF; bus64.wstrb = 8'hFF;
    bus64.awvalid = 1'b1; bus64.wvalid = 1'b1;
    c = 0;
    while (!(bus64.awready && bus64.wready) && c < 20) begin tick(); c++; end
    if (c == 20) fail_now("w64_ready");
    tick();
    bus64.awvalid = 1'b0; bus64.wvalid = 1'b0;
    check("w64_b_not_yet", bus64.bvalid, 1'b0);
    tick();
    check("w64_b", {bus64.bvalid, bus64.bresp, wr_pulse64}, {1'b1, 2'b00, 4'b0010});
    check("w64_regq", reg_q64, {64'h0, 64'h0, 64'h0123456789ABCDEF, 64'h0});
    bus64.araddr = 6'h08; bus64.arvalid = 1'b1;
    check("r64_arready", bus64.arready, 1'b1);
    tick();
    bus64.arvalid = 1'b0;
    tick();
    check("r64_r", {bus64.rvalid, bus64.rresp, bus64.rdata}, {1'b1, 2'b00, 64'h0123456789ABCDEF});
    tick();

    // Randomized traffic against the array model.
    do_reset();
    for (int n = 0; n < 120; n++) begin
      logic [AW-1:0] addr;
      logic [31:0]   data;
      logic [3:0]    strb;
      int            idx;
      logic [1:0]    exp_resp;
      logic [31:0]   exp_data;
      logic [NR-1:0] exp_pulse;
      addr = AW'($urandom_range(0, 63));
      data = $urandom;
      strb = 4'($urandom_range(0, 15));
      idx  = int'(addr) / 4;
      if ($urandom_range(0, 1) == 1) begin
        exp_resp  = (idx < NR && !RO[idx % NR]) ? 2'b00 : 2'b10;
        exp_pulse = (exp_resp == 2'b00) ? NR'(1) << idx : '0;
        axi_wr(addr, data, strb, resp, pulse, lat);
        check("rnd_bresp", resp, exp_resp);
        check("rnd_pulse", pulse, exp_pulse);
        if (exp_resp == 2'b00) begin
          for (int b = 0; b < 4; b++) if (strb[b]) mdl[idx][b*8 +: 8] = data[b*8 +: 8];
        end
      end else begin
        hw_status[7*DW +: DW] = $urandom;
        if (idx >= NR) begin
          exp_data = '0; exp_resp = 2'b10;
        end else if (RO[idx]) begin
          exp_data = hw_status[idx*DW +: DW]; exp_resp = 2'b00;
        end else begin
          exp_data = mdl[idx]; exp_resp = 2'b00;
        end
        axi_rd(addr, rdata, resp, lat);
        check("rnd_rdata", rdata, exp_data);
        check("rnd_rresp", resp, exp_resp);
        check("rnd_rlat", lat, 1);
      end
    end
    tick();
    exp_vec = '0;
    for (int i = 0; i < NR; i++) if (!RO[i]) exp_vec[i*DW +: DW] = mdl[i];
    check("rnd_regq_final", reg_q, exp_vec);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
